// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the serial pattern detection controller.
// The cfg struct is sized from the package defaults, which the top-level parameters follow.
package seq_det_pkg;

    localparam int unsigned SD_MAX_LEN = 8;
    localparam int unsigned SD_CNT_W   = 8;
    localparam int unsigned SD_LEN_W   = $clog2(SD_MAX_LEN + 1);

    typedef enum logic [1:0] {IDLE, CFGD, RUN, DONE} ctrl_state_t;

    typedef struct packed {
        logic [SD_MAX_LEN-1:0] pattern;
        logic [SD_LEN_W-1:0]   len;
        logic [SD_CNT_W-1:0]   target;
        logic                  overlap;
    } cfg_t;

    function automatic logic len_legal(input int unsigned len, input int unsigned max_len);
        return (len != 0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/seq_match_window.sv
// Shift window, fill counter and length-masked pattern compare.
// hit is combinational and reflects the bit being shifted in this cycle.
module seq_match_window
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = SD_MAX_LEN,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk_c,
    input  logic               reset_r,
    input  logic               shift_en,
    input  logic               din,
    input  logic               clear,
    input  logic [LEN_W-1:0]   len,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic               overlap,
    output logic               hit
);

    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] window_new;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_new;

    always_comb begin
        window_new = {window[MAX_LEN-2:0], din};
        fill_new   = (fill == LEN_W'(MAX_LEN)) ? fill : fill + 1'b1;
        mask       = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            mask[i] = (i < int'(len));
        end
        hit = shift_en && (fill_new >= len) && (((window_new ^ pattern) & mask) == '0);
    end

    always_ff @(posedge clk_c) begin
        if (!reset_r || clear) begin
            window <= '0;
            fill   <= '0;
        end else if (shift_en) begin
            window <= window_new;
            // Non-overlapping mode demands len fresh bits before the next match.
            fill   <= (hit && !overlap) ? '0 : fill_new;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run-time controller: config handshake, arm/disarm, match counting and completion.
// All outputs are registered; the match window lives in seq_match_window.
module seq_detect_ctrl
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = SD_MAX_LEN,
    parameter int unsigned CNT_W   = SD_CNT_W,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk_c,
    input  logic               reset_r,
    input  logic               cfg_valid_i,
    output logic               cfg_ready_o,
    input  logic [MAX_LEN-1:0] cfg_pattern_i,
    input  logic [LEN_W-1:0]   cfg_len_i,
    input  logic [CNT_W-1:0]   cfg_target_i,
    input  logic               cfg_overlap_i,
    output logic               cfg_err_o,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               bit_valid_i,
    input  logic               bit_i,
    output logic               match_o,
    output logic [CNT_W-1:0]   match_cnt_o,
    output logic               busy_o,
    output logic               done_o
);

    ctrl_state_t      state;
    cfg_t             cfg;
    logic             hit;
    logic             shift_en;
    logic             len_ok;
    logic [CNT_W-1:0] cnt_inc;

    assign len_ok   = len_legal(32'(cfg_len_i), MAX_LEN);
    // stop_i masks the shift so a completing bit in a stop cycle never counts.
    assign shift_en = (state == RUN) && bit_valid_i && !stop_i;
    assign cnt_inc  = (&match_cnt_o) ? match_cnt_o : match_cnt_o + 1'b1;

    seq_match_window #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_window (
        .clk_c    (clk_c),
        .reset_r  (reset_r),
        .shift_en (shift_en),
        .din      (bit_i),
        .clear    (state != RUN),
        .len      (cfg.len),
        .pattern  (cfg.pattern),
        .overlap  (cfg.overlap),
        .hit      (hit)
    );

    always_ff @(posedge clk_c) begin
        if (!reset_r) begin
            state       <= IDLE;
            cfg         <= '0;
            cfg_ready_o <= 1'b1;
            cfg_err_o   <= 1'b0;
            match_o     <= 1'b0;
            match_cnt_o <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            match_o   <= 1'b0;
            cfg_err_o <= 1'b0;
            unique case (state)
                IDLE, CFGD: begin
                    if (cfg_valid_i) begin
                        if (len_ok) begin
                            cfg   <= '{pattern: cfg_pattern_i, len: cfg_len_i,
                                       target: cfg_target_i, overlap: cfg_overlap_i};
                            state <= CFGD;
                        end else begin
                            cfg_err_o <= 1'b1;
                        end
                    end else if (start_i && state == CFGD) begin
                        state       <= RUN;
                        match_cnt_o <= '0;
                        cfg_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop_i) begin
                        state       <= CFGD;
                        cfg_ready_o <= 1'b1;
                        busy_o      <= 1'b0;
                    end else if (hit) begin
                        match_o     <= 1'b1;
                        match_cnt_o <= cnt_inc;
                        if (cfg.target != '0 && cnt_inc == cfg.target) begin
                            state  <= DONE;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (stop_i) begin
                        state       <= CFGD;
                        cfg_ready_o <= 1'b1;
                        done_o      <= 1'b0;
                    end else if (start_i) begin
                        state       <= RUN;
                        match_cnt_o <= '0;
                        busy_o      <= 1'b1;
                        done_o      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
